// File: rtl/enc_fifo_pkg.sv
// Shared types and defaults for the priority-encoder event FIFO.
package enc_fifo_pkg;

   typedef logic [1:0] idx_t;

   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/enc_fifo_mem.sv
// DEPTH x idx_t storage: one synchronous write port, one asynchronous read port.
module enc_fifo_mem
   import enc_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = $clog2(DEPTH_DEF)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  idx_t          wdata,
   input  logic [AW-1:0] raddr,
   output idx_t          rdata
);

   idx_t mem_q [DEPTH];

   // No reset: entries are only observable through count-qualified reads.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/enc_event_fifo.sv
// Event FIFO for priority-encoder indices with sticky overflow and optional per-index
// histogram, compiled in by defining ENC_FIFO_HIST_EN.
module enc_event_fifo
   import enc_fifo_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  idx_t                     in_y,
   output logic                     out_valid,
   input  logic                     out_ready,
   output idx_t                     out_y,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   input  logic                     clr_ovf,
   input  logic                     clr_hist,
   input  idx_t                     hist_sel,
   output logic [CNT_W-1:0]         hist_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          push, pop, drop;
   idx_t          rd_data;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CW'(DEPTH));
   assign count     = count_q;
   assign out_valid = !empty;
   assign overflow  = overflow_q;

   assign pop  = out_valid && out_ready;
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;

   // Gate the raw read so out_y reads 0 whenever nothing is stored.
   assign out_y = empty ? '0 : rd_data;

   enc_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (in_y),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         // A drop in the same cycle as clr_ovf keeps the flag set.
         if (drop)         overflow_q <= 1'b1;
         else if (clr_ovf) overflow_q <= 1'b0;
      end
   end

`ifdef ENC_FIFO_HIST_EN
   logic [CNT_W-1:0] hist_q [4];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      end else if (clr_hist) begin
         for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      end else if (push && (hist_q[in_y] != '1)) begin
         hist_q[in_y] <= hist_q[in_y] + CNT_W'(1);
      end
   end

   assign hist_cnt = hist_q[hist_sel];
`else
   logic unused_hist;

   assign unused_hist = ^{clr_hist, hist_sel};
   assign hist_cnt    = '0;
`endif

endmodule

// File: tb/tb_enc_event_fifo.sv
// Self-checking bench for enc_event_fifo: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_enc_event_fifo;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic [1:0]       in_y = 2'd0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [1:0]       out_y;
   logic [2:0]       count;
   logic             full, empty, overflow;
   logic             clr_ovf = 1'b0;
   logic             clr_hist = 1'b0;
   logic [1:0]       hist_sel = 2'd0;
   logic [CNT_W-1:0] hist_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   enc_event_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_y      (in_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf),
      .clr_hist  (clr_hist),
      .hist_sel  (hist_sel),
      .hist_cnt  (hist_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: plain queue, sticky flag and saturating counters.
   int m_q[$];
   bit m_ovf;
   int m_hist[4];

   always @(negedge rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         bit do_pop, do_push, do_drop;
         do_pop  = (m_q.size() > 0) && out_ready;
         do_push = in_valid && ((m_q.size() < DEPTH) || do_pop);
         do_drop = in_valid && !do_push;
         if (do_pop) void'(m_q.pop_front());
         if (do_push) m_q.push_back(int'(in_y));
         if (do_drop) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
`ifdef ENC_FIFO_HIST_EN
         if (clr_hist) begin
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
         end else if (do_push && m_hist[in_y] < (2 ** CNT_W) - 1) begin
            m_hist[in_y]++;
         end
`endif
      end
   end

   always @(negedge clk) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("m_out_y", 32'(out_y), 32'(m_q[0]));
      chk("m_count", 32'(count), 32'(m_q.size()));
      chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
`ifdef ENC_FIFO_HIST_EN
      chk("m_hist_cnt", 32'(hist_cnt), 32'(m_hist[hist_sel]));
`else
      chk("m_hist_cnt", 32'(hist_cnt), 32'd0);
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int a, input int b, input int c, input int d);
      int v[4];
      v = '{a, b, c, d};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_y     = 2'(v[i]);
         tick();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int exp_seq[4];

      // Reset state
      tick();
      tick();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_y", 32'(out_y), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_hist", 32'(hist_cnt), 32'd0);
      rst = 1'b1;
      tick();

      // One-cycle latency, no bypass
      in_valid = 1'b1;
      in_y     = 2'd1;
      #1;
      chk("lat_same_cycle_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("lat_next_valid", 32'(out_valid), 32'd1);
      chk("lat_next_y", 32'(out_y), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("lat_drained", 32'(empty), 32'd1);

      // Fill then drain in order
      fill(3, 2, 1, 0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd4);
      exp_seq   = '{3, 2, 1, 0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_y", 32'(out_y), 32'(exp_seq[i]));
         tick();
      end
      out_ready = 1'b0;
      chk("drain_empty", 32'(empty), 32'd1);

      // Overflow on drop; drop beats clr_ovf
      fill(0, 1, 2, 3);
      in_valid = 1'b1;
      in_y     = 2'd2;
      tick();
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd4);
      chk("ovf_head", 32'(out_y), 32'd0);
      clr_ovf = 1'b1;
      tick();
      chk("ovf_drop_wins", 32'(overflow), 32'd1);
      in_valid = 1'b0;
      tick();
      clr_ovf = 1'b0;
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Push and pop while full, across pointer wrap
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_y = 2'(k % 4);
         tick();
         if (k == 0) begin
            chk("pp_full_count", 32'(count), 32'd4);
            chk("pp_full_head", 32'(out_y), 32'd1);
         end
      end
      chk("pp_wrap_head", 32'(out_y), 32'd2);
      chk("pp_wrap_count", 32'(count), 32'd4);

      // Asynchronous reset mid-stream with count=3 and overflow set
      out_ready = 1'b0;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd3);
      chk("pre_rst_ovf", 32'(overflow), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_ovf", 32'(overflow), 32'd0);
      tick();
      rst      = 1'b1;
      in_valid = 1'b1;
      in_y     = 2'd3;
      tick();
      in_valid = 1'b0;
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_y", 32'(out_y), 32'd3);

      // Histogram saturation and clear
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_y      = 2'd0;
      for (int i = 0; i < 5; i++) tick();
      in_valid = 1'b0;
      hist_sel = 2'd0;
      #1;
`ifdef ENC_FIFO_HIST_EN
      chk("hist_sat", 32'(hist_cnt), 32'd3);
      hist_sel = 2'd3;
      #1;
      chk("hist_sel3", 32'(hist_cnt), 32'd1);
`else
      chk("hist_off", 32'(hist_cnt), 32'd0);
`endif
      clr_hist = 1'b1;
      in_valid = 1'b1;
      in_y     = 2'd3;
      tick();
      clr_hist = 1'b0;
      in_valid = 1'b0;
      chk("hist_clear", 32'(hist_cnt), 32'd0);
      out_ready = 1'b0;
      tick();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 9) < 6);
         in_y      = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 1) == 1);
         clr_ovf   = ($urandom_range(0, 15) == 0);
         clr_hist  = ($urandom_range(0, 31) == 0);
         hist_sel  = 2'($urandom_range(0, 3));
         tick();
      end
      in_valid = 1'b0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/enc_event_fifo.md
ENC_EVENT_FIFO -- requirements
Module: enc_event_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entries; power of two, >= 2.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of each histogram counter.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  priority-encoder valid; an event is offered this cycle.
REQ-006 The block SHALL have port in_y  input  2  priority-encoder index Y for the offered event.
REQ-007 The block SHALL have port out_valid  output  1  head entry available to consumer.
REQ-008 The block SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-009 The block SHALL have port out_y  output  2  index held in head entry.
REQ-010 The block SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-011 The block SHALL have ports full and empty  output  1 each  count==DEPTH, count==0.
REQ-012 The block SHALL have port overflow  output  1  sticky flag: an offered event was dropped.
REQ-013 The block SHALL have port clr_ovf  input  1  synchronous clear of overflow.
REQ-014 The block SHALL have port clr_hist  input  1  synchronous clear of all histogram counters.
REQ-015 The block SHALL have port hist_sel  input  2  selects histogram counter to read.
REQ-016 The block SHALL have port hist_cnt  output  CNT_W  value of counter hist_sel.

Function
REQ-017 Push SHALL occur when in_valid && (!full || pop); pop SHALL occur when out_valid && out_ready.
REQ-018 out_valid SHALL equal !empty; out_y SHALL be the oldest stored entry; out_y SHALL hold stable while out_valid && !out_ready.
REQ-019 Latency SHALL be one cycle: an event pushed at edge N is visible on out_valid/out_y after edge N; no same-cycle bypass when empty.
REQ-020 Simultaneous push and pop SHALL leave count unchanged, including when full (pushed entry accepted) and when count==1.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; ordering SHALL be strict FIFO across wrap.
REQ-022 in_valid while full and no pop SHALL drop the event, leave contents unchanged, and set overflow at the next edge.
REQ-023 clr_ovf SHALL clear overflow at the next edge; a drop in the same cycle SHALL win (overflow stays 1).
REQ-024 Pop while empty SHALL be impossible (out_valid=0); out_ready while empty SHALL have no effect.
REQ-025 in_y SHALL be ignored when in_valid=0.

Reset
REQ-026 Assertion of rst (low) SHALL immediately clear pointers, count=0, empty=1, full=0, out_valid=0, out_y=0, overflow=0, all histogram counters=0.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries; first push after release SHALL appear as the head one cycle later.

Configuration
REQ-028 Macro ENC_FIFO_HIST_EN SHALL compile in four CNT_W-bit counters, one per index, each incrementing on every accepted push of that index and saturating at all-ones.
REQ-029 With ENC_FIFO_HIST_EN, clr_hist SHALL zero all counters at the next edge; a push in the same cycle SHALL be discarded from the count (clear wins); hist_cnt SHALL be combinational from hist_sel.
REQ-030 Without ENC_FIFO_HIST_EN, ports SHALL remain present, hist_cnt SHALL be tied to 0, clr_hist and hist_sel SHALL be ignored, and no counter flops SHALL exist.

Structure
REQ-031 Package enc_fifo_pkg SHALL hold typedef idx_t (2-bit index), DEPTH_DEF=4 and CNT_W_DEF=8.
REQ-032 Storage SHALL be a sub-module enc_fifo_mem (DEPTH x idx_t, one write port, one asynchronous read port); pointers, flags and histogram SHALL stay in enc_event_fifo.

Verification
REQ-033 Reset, push in_y=3,2,1,0 with out_ready=0 -> full=1, count=4; then out_ready=1 -> out_y 3,2,1,0 on consecutive cycles, then empty=1.
REQ-034 Full, in_valid=1 in_y=2, out_ready=0 -> overflow=1, contents unchanged; clr_ovf=1 with concurrent drop -> overflow stays 1; clr_ovf alone -> 0.
REQ-035 Full, in_valid=1 and out_ready=1 same cycle -> count stays 4, new entry emerges last; 10 push/pop cycles -> order preserved across pointer wrap.
REQ-036 Empty, push in_y=1 -> out_valid=0 same cycle, out_valid=1 and out_y=1 next cycle.
REQ-037 rst low mid-stream with count=3 -> count=0, out_valid=0, overflow=0 immediately, before the next clk edge.
REQ-038 ENC_FIFO_HIST_EN, CNT_W=2: five pushes of in_y=0 -> hist_cnt(sel 0)=3 saturated; clr_hist -> 0; without macro hist_cnt=0 throughout.
